// File: rtl/im_arbiter_pkg.sv
// Shared encodings for the instruction-memory read-port arbiter:
// FSM states and the requester/owner identifiers.
package im_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/im_arbiter_pick.sv
// Combinational winner select between fetch (F) and debug (D) requesters.
// IMA_RR_EN selects round-robin on contention; otherwise F has fixed priority.
module im_arb_pick
    import im_arbiter_pkg::*;
(
    input  logic   f_req,
    input  logic   d_req,
    input  owner_t last_owner,
    output logic   pick_vld,
    output owner_t pick_owner
);

`ifndef IMA_RR_EN
    // Fixed priority has no use for history; keep the port tied off for lint.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        pick_vld   = f_req | d_req;
        pick_owner = OWN_F;
        if (f_req && d_req) begin
`ifdef IMA_RR_EN
            pick_owner = (last_owner == OWN_F) ? OWN_D : OWN_F;
`else
            pick_owner = OWN_F;
`endif
        end else if (d_req) begin
            pick_owner = OWN_D;
        end
    end

endmodule

// File: rtl/im_arbiter.sv
// Arbitrates the instruction-memory read port between fetch and debug requesters.
// Optional round-robin arbitration on contention is enabled by defining IMA_RR_EN.
module im_arbiter
    import im_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_valid,
    output logic [DW-1:0] f_data,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_data,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_rdata,
    output logic          busy
);

    state_t state_q, state_d;
    owner_t owner_q, last_owner_q;
    owner_t pick_owner;
    logic   pick_vld;
    logic   arb_en;
    logic   grant;

    im_arb_pick u_pick (
        .f_req      (f_req),
        .d_req      (d_req),
        .last_owner (last_owner_q),
        .pick_vld   (pick_vld),
        .pick_owner (pick_owner)
    );

    // Grants only open in IDLE/RESP, and are held off while reset is asserted.
    assign arb_en = !rst && ((state_q == IDLE) || (state_q == RESP));
    assign grant  = arb_en && pick_vld;
    assign f_gnt  = grant && (pick_owner == OWN_F);
    assign d_gnt  = grant && (pick_owner == OWN_D);

    assign busy    = (state_q == ACCESS);
    assign f_valid = (state_q == RESP) && (owner_q == OWN_F);
    assign d_valid = (state_q == RESP) && (owner_q == OWN_D);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = grant ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_F;
            last_owner_q <= OWN_D;
            im_addr      <= '0;
            f_data       <= '0;
            d_data       <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                im_addr      <= (pick_owner == OWN_F) ? f_addr : d_addr;
                owner_q      <= pick_owner;
                last_owner_q <= pick_owner;
            end
            // Memory read is combinational: the word is stable by the end of ACCESS.
            if (state_q == ACCESS) begin
                if (owner_q == OWN_F) begin
                    f_data <= im_rdata;
                end else begin
                    d_data <= im_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_arbiter.sv
// Directed, table-driven bench for im_arbiter with a combinational memory model.
module tb_im_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    localparam logic [31:0] M4  = 32'h1234_5678;
    localparam logic [31:0] M10 = 32'hA5AF_000A;
    localparam logic [31:0] M11 = 32'hA5AE_000B;
    localparam logic [31:0] M20 = 32'hA5B1_0014;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req;
    logic [AW-1:0] f_addr, d_addr;
    logic          f_gnt, f_valid, d_gnt, d_valid, busy;
    logic [DW-1:0] f_data, d_data, im_rdata;
    logic [AW-1:0] im_addr;

    int n_chk  = 0;
    int n_fail = 0;

    im_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_valid  (f_valid),
        .f_data   (f_data),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_data   (d_data),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [15:0] a);
        if (a == 16'h0004) return 32'h1234_5678;
        return {a ^ 16'hA5A5, a};
    endfunction

    always_comb im_rdata = memf(im_addr);

    typedef struct {
        logic        rst, f_req, d_req;
        logic [15:0] f_addr, d_addr;
        logic        f_gnt, d_gnt, busy, f_valid, d_valid;
        logic [15:0] im_addr;
        logic [31:0] f_data, d_data;
    } vec_t;

    vec_t tv [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic fr, input logic dr,
                         input logic [15:0] fa, input logic [15:0] da);
        @(negedge clk);
        rst = r; f_req = fr; d_req = dr; f_addr = fa; d_addr = da;
        #2;
        chk("gnt_excl", 64'(f_gnt & d_gnt), 64'd0);
    endtask

    initial begin
        // rst, f_req, d_req, f_addr, d_addr, f_gnt, d_gnt, busy, f_valid, d_valid, im_addr, f_data, d_data
        tv[0]  = '{1, 1, 1, 16'd4,  16'd7,  0, 0, 0, 0, 0, 16'd0,  32'h0, 32'h0};
        tv[1]  = '{1, 1, 1, 16'd4,  16'd7,  0, 0, 0, 0, 0, 16'd0,  32'h0, 32'h0};
        tv[2]  = '{0, 1, 0, 16'd4,  16'd7,  1, 0, 0, 0, 0, 16'd0,  32'h0, 32'h0};
        tv[3]  = '{0, 0, 0, 16'd4,  16'd7,  0, 0, 1, 0, 0, 16'd4,  32'h0, 32'h0};
        tv[4]  = '{0, 0, 0, 16'd4,  16'd7,  0, 0, 0, 1, 0, 16'd4,  M4,    32'h0};
        tv[5]  = '{0, 0, 0, 16'd4,  16'd7,  0, 0, 0, 0, 0, 16'd4,  M4,    32'h0};
        tv[6]  = '{1, 0, 0, 16'd10, 16'd20, 0, 0, 0, 0, 0, 16'd4,  M4,    32'h0};
`ifdef IMA_RR_EN
        tv[7]  = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 0, 0, 16'd0,  32'h0, 32'h0};
        tv[8]  = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, 32'h0, 32'h0};
        tv[9]  = '{0, 1, 1, 16'd10, 16'd20, 0, 1, 0, 1, 0, 16'd10, M10,   32'h0};
        tv[10] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd20, M10,   32'h0};
        tv[11] = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 0, 1, 16'd20, M10,   M20};
        tv[12] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, M10,   M20};
        tv[13] = '{0, 1, 1, 16'd10, 16'd20, 0, 1, 0, 1, 0, 16'd10, M10,   M20};
        tv[14] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd20, M10,   M20};
        tv[15] = '{0, 0, 0, 16'd10, 16'd20, 0, 0, 0, 0, 1, 16'd20, M10,   M20};
        tv[16] = '{0, 0, 0, 16'd10, 16'd20, 0, 0, 0, 0, 0, 16'd20, M10,   M20};
`else
        tv[7]  = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 0, 0, 16'd0,  32'h0, 32'h0};
        tv[8]  = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, 32'h0, 32'h0};
        tv[9]  = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 1, 0, 16'd10, M10,   32'h0};
        tv[10] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, M10,   32'h0};
        tv[11] = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 1, 0, 16'd10, M10,   32'h0};
        tv[12] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, M10,   32'h0};
        tv[13] = '{0, 1, 1, 16'd10, 16'd20, 1, 0, 0, 1, 0, 16'd10, M10,   32'h0};
        tv[14] = '{0, 1, 1, 16'd10, 16'd20, 0, 0, 1, 0, 0, 16'd10, M10,   32'h0};
        tv[15] = '{0, 0, 0, 16'd10, 16'd20, 0, 0, 0, 1, 0, 16'd10, M10,   32'h0};
        tv[16] = '{0, 0, 0, 16'd10, 16'd20, 0, 0, 0, 0, 0, 16'd10, M10,   32'h0};
`endif

        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
        @(negedge clk);

        // Reset, single fetch, contention run
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].rst, tv[i].f_req, tv[i].d_req, tv[i].f_addr, tv[i].d_addr);
            chk($sformatf("v%0d f_gnt", i),   64'(f_gnt),   64'(tv[i].f_gnt));
            chk($sformatf("v%0d d_gnt", i),   64'(d_gnt),   64'(tv[i].d_gnt));
            chk($sformatf("v%0d busy", i),    64'(busy),    64'(tv[i].busy));
            chk($sformatf("v%0d f_valid", i), 64'(f_valid), 64'(tv[i].f_valid));
            chk($sformatf("v%0d d_valid", i), 64'(d_valid), 64'(tv[i].d_valid));
            chk($sformatf("v%0d im_addr", i), 64'(im_addr), 64'(tv[i].im_addr));
            chk($sformatf("v%0d f_data", i),  64'(f_data),  64'(tv[i].f_data));
            chk($sformatf("v%0d d_data", i),  64'(d_data),  64'(tv[i].d_data));
        end

        // D access at the top address, aborted by reset during ACCESS
        drive(0, 0, 1, 16'h0000, 16'hFFFF);
        chk("abort d_gnt", 64'(d_gnt), 64'd1);
        chk("abort f_gnt", 64'(f_gnt), 64'd0);
        drive(1, 0, 0, 16'h0000, 16'hFFFF);
        chk("abort busy", 64'(busy), 64'd1);
        chk("abort im_addr", 64'(im_addr), 64'hFFFF);
        drive(0, 0, 0, 16'h0000, 16'h0000);
        chk("abort d_valid", 64'(d_valid), 64'd0);
        chk("abort d_data", 64'(d_data), 64'd0);
        chk("abort f_data", 64'(f_data), 64'd0);
        chk("abort busy2", 64'(busy), 64'd0);
        chk("abort im_addr2", 64'(im_addr), 64'd0);
        drive(0, 0, 0, 16'h0000, 16'h0000);
        chk("abort d_valid2", 64'(d_valid), 64'd0);
        chk("abort busy3", 64'(busy), 64'd0);

        // Back-to-back F reads, plus a D request dropped before it is granted
        drive(0, 1, 0, 16'd10, 16'd0);
        chk("b2b gnt1", 64'(f_gnt), 64'd1);
        drive(0, 1, 0, 16'd11, 16'd0);
        chk("b2b access f_gnt", 64'(f_gnt), 64'd0);
        chk("b2b access im_addr", 64'(im_addr), 64'd10);
        drive(0, 1, 0, 16'd11, 16'd0);
        chk("b2b resp1 f_valid", 64'(f_valid), 64'd1);
        chk("b2b resp1 f_data", 64'(f_data), 64'(M10));
        chk("b2b gnt2", 64'(f_gnt), 64'd1);
        drive(0, 0, 1, 16'd0, 16'd5);
        chk("b2b access2 im_addr", 64'(im_addr), 64'd11);
        chk("b2b access2 f_valid", 64'(f_valid), 64'd0);
        chk("drop d_gnt", 64'(d_gnt), 64'd0);
        drive(0, 0, 0, 16'd0, 16'd0);
        chk("b2b resp2 f_valid", 64'(f_valid), 64'd1);
        chk("b2b resp2 f_data", 64'(f_data), 64'(M11));
        chk("drop d_gnt2", 64'(d_gnt), 64'd0);
        drive(0, 0, 0, 16'd0, 16'd0);
        chk("b2b idle f_valid", 64'(f_valid), 64'd0);
        chk("b2b hold f_data", 64'(f_data), 64'(M11));
        chk("drop busy", 64'(busy), 64'd0);
        chk("drop d_valid", 64'(d_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
